// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter.
//   BCD_DIGIT_W  width of one packed BCD digit
//   bcd_state_e  converter FSM states
//   bcd_add3     double-dabble correction of one digit
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  // A digit of 5 or more would exceed 9 once doubled; adding 3 first makes the
  // doubling carry correctly into the next digit.
  function automatic logic [BCD_DIGIT_W-1:0] bcd_add3(input logic [BCD_DIGIT_W-1:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bcd_converter_if.sv
// Handshake bundle of the binary-to-BCD converter.
//   in_valid/in_ready/bin_in           operand handshake (producer -> converter)
//   out_valid/out_ready                result handshake (converter -> consumer)
//   bcd_out/overflow/neg               result payload
// Modports: master = producer/consumer side, slave = converter side.
interface bcd_converter_if #(
  parameter int unsigned BIN_W  = 12,
  parameter int unsigned DIGITS = 4
);
  import bcd_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [BIN_W-1:0]              bin_in;
  logic                          out_valid;
  logic                          out_ready;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
  logic                          overflow;
  logic                          neg;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, overflow, neg
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, overflow, neg
  );

endinterface

// File: rtl/bcd_digit_cell.sv
// One stage of the double-dabble digit chain: correct the digit, then shift it
// left by one taking shift_in as the new LSB.
//   digit       current digit value
//   shift_in    bit arriving from the next-lower digit (or the operand)
//   digit_next  corrected and shifted digit
//   shift_out   bit leaving toward the next-higher digit
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  input  logic                   shift_in,
  output logic [BCD_DIGIT_W-1:0] digit_next,
  output logic                   shift_out
);

  logic [BCD_DIGIT_W-1:0] corrected;

  always_comb begin
    corrected  = bcd_add3(digit);
    digit_next = {corrected[BCD_DIGIT_W-2:0], shift_in};
    shift_out  = corrected[BCD_DIGIT_W-1];
  end

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one operand bit per cycle).
// Parameters: BIN_W (1..32) operand width, DIGITS (1..10) BCD digits produced.
// Ports:
//   clk    rising-edge clock
//   n_rst  asynchronous active-low reset
//   bus    bcd_converter_if.slave: operand/result handshakes, bcd_out, overflow, neg
// Optional feature: define BCD_SIGNED_EN to treat bin_in as two's complement
// (neg reports the sign, the magnitude is converted). Default build is unsigned
// with neg tied low.
module bcd_converter
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 12,
  parameter int unsigned DIGITS = 4
) (
  input logic             clk,
  input logic             n_rst,
  bcd_converter_if.slave  bus
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [BCD_W-1:0] NINES = {DIGITS{4'h9}};

  if (BIN_W < 1 || BIN_W > 32) begin : g_bin_w_check
    $error("bcd_converter: BIN_W must be within 1..32");
  end
  if (DIGITS < 1 || DIGITS > 10) begin : g_digits_check
    $error("bcd_converter: DIGITS must be within 1..10");
  end

  bcd_state_e       state_q, state_d;
  logic [BIN_W-1:0] op_q, op_d;
  logic [BCD_W-1:0] dig_q, dig_d;
  logic [BCD_W-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
`ifdef BCD_SIGNED_EN
  logic             neg_q, neg_d;
`endif

  // Digit chain: the operand MSB enters digit 0, carries ripple upward, and
  // whatever leaves the top digit marks the value as too large.
  logic [DIGITS:0]  carry;
  logic [BCD_W-1:0] dig_shifted;

  assign carry[0] = op_q[BIN_W-1];

  for (genvar i = 0; i < DIGITS; i++) begin : g_cell
    bcd_digit_cell u_cell (
      .digit      (dig_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .shift_in   (carry[i]),
      .digit_next (dig_shifted[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .shift_out  (carry[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dig_d   = dig_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef BCD_SIGNED_EN
    neg_d   = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef BCD_SIGNED_EN
          // The most negative value negates to itself, which is exactly its
          // magnitude when read as unsigned.
          neg_d = bus.bin_in[BIN_W-1];
          op_d  = bus.bin_in[BIN_W-1] ? (~bus.bin_in + BIN_W'(1)) : bus.bin_in;
`else
          op_d  = bus.bin_in;
`endif
          dig_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        op_d  = op_q << 1;
        dig_d = dig_shifted;
        ovf_d = ovf_q | carry[DIGITS];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          res_d   = (ovf_q | carry[DIGITS]) ? NINES : dig_shifted;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      dig_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef BCD_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dig_q   <= dig_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
`ifdef BCD_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.bcd_out   = res_q;
  assign bus.overflow  = ovf_q;
`ifdef BCD_SIGNED_EN
  assign bus.neg       = neg_q;
`else
  assign bus.neg       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: dut0 (BIN_W=12, DIGITS=4) and dut1
// (BIN_W=10, DIGITS=3). Drivers push hand-computed expectations at issue time;
// per-DUT monitors pop and compare at each result handshake.
// Expectations follow BCD_SIGNED_EN when that macro is defined.
module tb_bcd_converter;

  logic clk = 1'b0;
  logic n_rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  logic [15:0] q0_bcd[$];
  logic [1:0]  q0_fl[$];
  logic [11:0] q0_in[$];
  logic [15:0] q1_bcd[$];
  logic [1:0]  q1_fl[$];
  logic [9:0]  q1_in[$];

  always #5 clk = ~clk;

  bcd_converter_if #(.BIN_W(12), .DIGITS(4)) bus0 ();
  bcd_converter_if #(.BIN_W(10), .DIGITS(3)) bus1 ();

  bcd_converter #(.BIN_W(12), .DIGITS(4)) dut0 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus0)
  );

  bcd_converter #(.BIN_W(10), .DIGITS(3)) dut1 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic send0(input logic [11:0] v, input logic [15:0] eb, input logic eo,
                       input logic en);
    int n = 0;
    @(negedge clk);
    while (!bus0.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus0.in_ready) begin
      total_cnt++;
      $display("FAIL send0_in_ready: got 0 required 1");
    end else begin
      bus0.bin_in   = v;
      bus0.in_valid = 1'b1;
      q0_bcd.push_back(eb);
      q0_fl.push_back({eo, en});
      q0_in.push_back(v);
      @(posedge clk);
      #1 bus0.in_valid = 1'b0;
    end
  endtask

  task automatic send1(input logic [9:0] v, input logic [15:0] eb, input logic eo,
                       input logic en);
    int n = 0;
    @(negedge clk);
    while (!bus1.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus1.in_ready) begin
      total_cnt++;
      $display("FAIL send1_in_ready: got 0 required 1");
    end else begin
      bus1.bin_in   = v;
      bus1.in_valid = 1'b1;
      q1_bcd.push_back(eb);
      q1_fl.push_back({eo, en});
      q1_in.push_back(v);
      @(posedge clk);
      #1 bus1.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0_bcd.size() != 0 || q1_bcd.size() != 0 || !bus0.in_ready || !bus1.in_ready)
           && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total_cnt++;
      $display("FAIL drain: results outstanding q0=%0d q1=%0d required 0", q0_bcd.size(),
               q1_bcd.size());
    end
  endtask

  // Monitors
  logic [15:0] m0_bcd, m1_bcd;
  logic [1:0]  m0_fl, m1_fl;
  logic [11:0] m0_in;
  logic [9:0]  m1_in;

  always @(negedge clk) begin
    if (n_rst && bus0.out_valid && bus0.out_ready) begin
      if (q0_bcd.size() == 0) begin
        total_cnt++;
        $display("FAIL dut0_unexpected: got result %h required none", bus0.bcd_out);
      end else begin
        m0_bcd = q0_bcd.pop_front();
        m0_fl  = q0_fl.pop_front();
        m0_in  = q0_in.pop_front();
        chk($sformatf("dut0_bcd in=%0h", m0_in), 32'(bus0.bcd_out), 32'(m0_bcd));
        chk($sformatf("dut0_ovf in=%0h", m0_in), 32'(bus0.overflow), 32'(m0_fl[1]));
        chk($sformatf("dut0_neg in=%0h", m0_in), 32'(bus0.neg), 32'(m0_fl[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (n_rst && bus1.out_valid && bus1.out_ready) begin
      if (q1_bcd.size() == 0) begin
        total_cnt++;
        $display("FAIL dut1_unexpected: got result %h required none", bus1.bcd_out);
      end else begin
        m1_bcd = q1_bcd.pop_front();
        m1_fl  = q1_fl.pop_front();
        m1_in  = q1_in.pop_front();
        chk($sformatf("dut1_bcd in=%0h", m1_in), 32'(bus1.bcd_out), 32'(m1_bcd));
        chk($sformatf("dut1_ovf in=%0h", m1_in), 32'(bus1.overflow), 32'(m1_fl[1]));
        chk($sformatf("dut1_neg in=%0h", m1_in), 32'(bus1.neg), 32'(m1_fl[0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    n_rst          = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.bin_in    = '0;
    bus0.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.bin_in    = '0;
    bus1.out_ready = 1'b1;
    #12;
    chk("rst_in_ready",  32'(bus0.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_bcd_out",   32'(bus0.bcd_out), 32'd0);
    chk("rst_overflow",  32'(bus0.overflow), 32'd0);
    chk("rst_neg",       32'(bus0.neg), 32'd0);
    chk("rst_out_valid1", 32'(bus1.out_valid), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    send0(12'd42, 16'h0042, 1'b0, 1'b0);
    drain();

    // Latency, result hold during SHIFT, and operand changes ignored in SHIFT
`ifdef BCD_SIGNED_EN
    send0(12'hFFF, 16'h0001, 1'b0, 1'b1);
`else
    send0(12'hFFF, 16'h4095, 1'b0, 1'b0);
`endif
    bus0.in_valid = 1'b1;
    bus0.bin_in   = 12'd7;
    lat  = 0;
    seen = 0;
    while (seen == 0 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin
        chk("shift_bcd_hold", 32'(bus0.bcd_out), 32'h0042);
        chk("shift_in_ready", 32'(bus0.in_ready), 32'd0);
        chk("shift_out_valid", 32'(bus0.out_valid), 32'd0);
      end
      if (bus0.out_valid) begin
        seen = 1;
        bus0.in_valid = 1'b0;
      end
    end
    bus0.in_valid = 1'b0;
    chk("latency_4095", 32'(lat), 32'd13);
    drain();

    send0(12'd0,    16'h0000, 1'b0, 1'b0);
    send0(12'd999,  16'h0999, 1'b0, 1'b0);
    send0(12'd9,    16'h0009, 1'b0, 1'b0);
    send0(12'd10,   16'h0010, 1'b0, 1'b0);
`ifdef BCD_SIGNED_EN
    send0(12'h800,  16'h2048, 1'b0, 1'b1);
`else
    send0(12'h800,  16'h2048, 1'b0, 1'b0);
`endif
    send0(12'h7FF,  16'h2047, 1'b0, 1'b0);

`ifdef BCD_SIGNED_EN
    send1(10'd999,  16'h0025, 1'b0, 1'b1);
    send1(10'd1000, 16'h0024, 1'b0, 1'b1);
    send1(10'd1023, 16'h0001, 1'b0, 1'b1);
    send1(10'd0,    16'h0000, 1'b0, 1'b0);
    send1(10'd512,  16'h0512, 1'b0, 1'b1);
`else
    send1(10'd999,  16'h0999, 1'b0, 1'b0);
    send1(10'd1000, 16'h0999, 1'b1, 1'b0);
    send1(10'd1023, 16'h0999, 1'b1, 1'b0);
    send1(10'd0,    16'h0000, 1'b0, 1'b0);
    send1(10'd512,  16'h0512, 1'b0, 1'b0);
`endif
    drain();

    // Backpressure on dut0
    @(posedge clk);
    #1 bus0.out_ready = 1'b0;
    send0(12'd1234, 16'h1234, 1'b0, 1'b0);
    lat = 0;
    while (!bus0.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_first_valid", 32'(bus0.out_valid), 32'd1);
    bus0.in_valid = 1'b1;
    bus0.bin_in   = 12'd999;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus0.out_valid), 32'd1);
      chk("bp_in_ready",  32'(bus0.in_ready), 32'd0);
      chk("bp_bcd_hold",  32'(bus0.bcd_out), 32'h1234);
    end
    bus0.in_valid = 1'b0;
    @(posedge clk);
    #1 bus0.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready",  32'(bus0.in_ready), 32'd1);
    chk("bp_idle_out_valid", 32'(bus0.out_valid), 32'd0);
    drain();

    // Reset in the sixth SHIFT cycle of 4095
    send0(12'hFFF, 16'h4095, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 n_rst = 1'b0;
    q0_bcd.delete();
    q0_fl.delete();
    q0_in.delete();
    #1;
    chk("mid_rst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("mid_rst_bcd_out",   32'(bus0.bcd_out), 32'd0);
    chk("mid_rst_overflow",  32'(bus0.overflow), 32'd0);
    chk("mid_rst_neg",       32'(bus0.neg), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(bus0.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.out_valid) seen++;
    end
    chk("mid_rst_no_result", 32'(seen), 32'd0);
    send0(12'd42, 16'h0042, 1'b0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_converter.md
BCD_CONVERTER -- requirements
Module: bcd_converter

Interface
REQ-001 The block SHALL have parameter BIN_W, default 12, binary input width, legal range 1..32.
REQ-002 The block SHALL have parameter DIGITS, default 4, BCD output digit count, legal range 1..10.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  bin_in holds a value to convert.
REQ-006 in_ready  output  1  block accepts a new value.
REQ-007 bin_in  input  BIN_W  binary operand.
REQ-008 out_valid  output  1  result is available.
REQ-009 out_ready  input  1  consumer takes the result.
REQ-010 bcd_out  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0].
REQ-011 overflow  output  1  operand not representable in DIGITS digits.
REQ-012 neg  output  1  operand was negative; held 0 without BCD_SIGNED_EN.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in SHIFT and DONE it SHALL be 0.
REQ-015 On a clock edge in IDLE with in_valid=1, the block SHALL:
- capture bin_in;
- clear the digit register, bit counter and overflow flag;
- enter SHIFT.
REQ-016 Each SHIFT cycle SHALL apply one double-dabble step:
- add 3 to every digit that is 5 or greater;
- shift the digit chain left by one, taking the next operand bit MSB-first.
REQ-017 After exactly BIN_W SHIFT cycles, the block SHALL enter DONE; out_valid SHALL first be 1 BIN_W+1 cycles after the accepting edge.
REQ-018 In DONE, out_valid SHALL be 1 and bcd_out/overflow/neg SHALL be stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-019 Back-to-back conversions SHALL have one IDLE cycle between results (no same-cycle handoff).
REQ-020 overflow SHALL be set sticky if a 1 shifts out of the MSB of the top digit during SHIFT.
REQ-021 When overflow=1, bcd_out SHALL be saturated to all digits 9.
REQ-022 Outside DONE, bcd_out SHALL retain the last result.
REQ-023 in_valid and bin_in SHALL be ignored outside IDLE.

Reset
REQ-024 Asserting n_rst SHALL immediately force:
- state IDLE;
- in_ready=1 after release;
- out_valid=0, bcd_out=0, overflow=0, neg=0;
- internal counters/registers to 0.
REQ-025 Reset during SHIFT or DONE SHALL abort the conversion with no result emitted.

Configuration
REQ-026 With macro BCD_SIGNED_EN defined, bin_in SHALL be treated as two's complement:
- on accept, neg SHALL capture the sign bit and the block SHALL convert the magnitude;
- -2^(BIN_W-1) SHALL convert correctly as unsigned magnitude.
REQ-027 Without BCD_SIGNED_EN, bin_in SHALL be unsigned, neg SHALL be tied 0, and no negation logic SHALL be synthesised.

Structure
REQ-028 Package bcd_pkg SHALL hold:
- the state enum (IDLE/SHIFT/DONE);
- constant BCD_DIGIT_W=4;
- the add-3 correction function.
REQ-029 Sub-module bcd_digit_cell SHALL implement one digit's correct-and-shift (inputs: digit, shift-in bit; outputs: next digit, shift-out bit), instantiated DIGITS times in a chain.
REQ-030 Elaboration SHALL fail for BIN_W or DIGITS outside the legal range.

Verification
REQ-031 Max value, BIN_W=12, DIGITS=4: bin_in=4095, in_valid pulse -> out_valid exactly 13 cycles after accept, bcd_out=16'h4095, overflow=0.
REQ-032 Zero: bin_in=0 -> bcd_out=16'h0000, overflow=0.
REQ-033 Overflow boundary, DIGITS=3, BIN_W=10:
- bin_in=999 -> bcd_out=12'h999, overflow=0;
- bin_in=1000 -> overflow=1, bcd_out=12'h999.
REQ-034 Backpressure: convert 1234 with out_ready held 0 for 5 cycles -> bcd_out=16'h1234, out_valid stays 1, in_ready stays 0 throughout, IDLE one cycle after out_ready=1.
REQ-035 Reset mid-operation: assert n_rst at SHIFT cycle 6 of 4095 -> all outputs 0 immediately, no out_valid; next conversion of 42 -> 16'h0042.
REQ-036 BCD_SIGNED_EN, BIN_W=12:
- bin_in=12'hFFF -> neg=1, bcd_out=16'h0001;
- bin_in=12'h800 -> neg=1, bcd_out=16'h2048;
- bin_in=12'h7FF -> neg=0, bcd_out=16'h2047.
